// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with a carry-save-free slice pipeline.
// The WIDTH-bit operation is split into STAGES slices of SW = WIDTH/STAGES
// bits. Stage k ripples slice k and registers its carry into stage k+1,
// while the untouched operand bits ride along in skew registers. A
// valid/ready handshake with a single global advance signal moves the
// whole pipeline at once; bubbles travel as invalid stages.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   beat accepted when in_valid && in_ready (= advance)
//   a, b       WIDTH-bit operands
//   cin        carry-in for add (ignored for subtract)
//   sub        0 = a + b + cin, 1 = a - b
//   sat        clamp signed result on overflow
//   out_valid  result beat present
//   out_ready  downstream accepts result
//   sum        WIDTH-bit result (saturated if requested)
//   cout       raw carry out of the MSB (1 = no borrow on subtract)
//   overflow   signed overflow of the unsaturated result
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SW  = WIDTH / STAGES;
  localparam int L   = STAGES - 1;
  localparam int MSB = WIDTH - 1;

  if (WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Stage registers. b_q holds the effective (already inverted for
  // subtract) operand, so the mode only matters when a beat enters.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] sat_q;
  logic [STAGES-1:0] v_q;

  // Values about to be loaded into each stage.
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] ci_d;
  logic [STAGES-1:0] sat_d;
  logic [STAGES-1:0] v_d;

  logic adv;
  logic ovf_raw;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_comb begin : p_stage
    logic c;
    a_d[0]   = a;
    b_d[0]   = sub ? ~b : b;
    s_d[0]   = '0;
    ci_d[0]  = sub | cin;   // subtract: a + ~b + 1
    sat_d[0] = sat;
    v_d[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_d[k]   = s_q[k-1];
      ci_d[k]  = c_q[k-1];
      sat_d[k] = sat_q[k-1];
      v_d[k]   = v_q[k-1];
    end
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      c = ci_d[k];
      for (int j = 0; j < SW; j++) begin
        s_d[k][k*SW+j] = a_d[k][k*SW+j] ^ b_d[k][k*SW+j] ^ c;
        c = (a_d[k][k*SW+j] & b_d[k][k*SW+j]) |
            (c & (a_d[k][k*SW+j] ^ b_d[k][k*SW+j]));
      end
      c_d[k] = c;
    end
  end

  // Data only loads behind a valid beat so the outputs keep their last
  // value (zero after reset) while bubbles pass through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      sat_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          s_q[k]   <= s_d[k];
          c_q[k]   <= c_d[k];
          sat_q[k] <= sat_d[k];
        end
      end
    end
  end

  assign out_valid = v_q[L];
  assign cout      = c_q[L];
  assign ovf_raw   = (a_q[L][MSB] == b_q[L][MSB]) && (s_q[L][MSB] != a_q[L][MSB]);
  assign overflow  = ovf_raw;

  always_comb begin
    sum = s_q[L];
    if (sat_q[L] && ovf_raw) begin
      sum = a_q[L][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule
